// File: rtl/lsu_pkg.sv
// Shared types for the LSU data-memory responder: error codes, FSM states, word size.
package lsu_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_MISALIGNED   = 2'd1,
    ERR_OUT_OF_RANGE = 2'd2,
    ERR_RW_COLLISION = 2'd3
  } lsu_err_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/lsu_dmem_addr_chk.sv
// Byte-address decode for the data memory: word index, misalignment and range checks.
module lsu_dmem_addr_chk
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic [31:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             misaligned,
  output logic             oob
);

  logic [31:0] off;

  // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
  always_comb begin
    off        = addr - BASE_ADDR;
    idx        = off[IDX_W+1:2];
    misaligned = |off[1:0];
    oob        = off >= 32'(DEPTH * WORD_BYTES);
  end

endmodule

// File: rtl/lsu_dmem_resp.sv
// LSU data-memory responder: word RAM with 1-cycle loads, post-reset clear, error flagging.
module lsu_dmem_resp
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        err,
  output logic [1:0]  err_code
);

  logic [31:0] mem [DEPTH];

  dmem_state_e      state;
  logic [IDX_W-1:0] clr_idx;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_mis;
  logic             rd_oob;
  logic             wr_mis;
  logic             wr_oob;

  logic             run;
  logic             rd_ok;
  logic             wr_ok;
  lsu_err_e         err_nxt;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;

  lsu_dmem_addr_chk #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_rd_chk (
    .addr       (rd_addr),
    .idx        (rd_idx),
    .misaligned (rd_mis),
    .oob        (rd_oob)
  );

  lsu_dmem_addr_chk #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_wr_chk (
    .addr       (wr_addr),
    .idx        (wr_idx),
    .misaligned (wr_mis),
    .oob        (wr_oob)
  );

  // Request qualification, error priority and the single RAM write port.
  always_comb begin
    run     = (state == RUN);
    wr_ok   = run & wr_en & ~wr_mis & ~wr_oob;
    rd_ok   = run & rd_en & ~wr_en & ~rd_mis & ~rd_oob;
    err_nxt = ERR_NONE;
    if (run) begin
      if (rd_en && wr_en) begin
        err_nxt = ERR_RW_COLLISION;
      end else if (rd_en) begin
        if (rd_mis)      err_nxt = ERR_MISALIGNED;
        else if (rd_oob) err_nxt = ERR_OUT_OF_RANGE;
      end else if (wr_en) begin
        if (wr_mis)      err_nxt = ERR_MISALIGNED;
        else if (wr_oob) err_nxt = ERR_OUT_OF_RANGE;
      end
    end

    mem_we    = 1'b0;
    mem_widx  = clr_idx;
    mem_wdata = '0;
    if (rst_n) begin
      if (!run) begin
        mem_we = 1'b1;
      end else if (wr_ok) begin
        mem_we    = 1'b1;
        mem_widx  = wr_idx;
        mem_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Clear/run FSM with registered responses; the read sees the array before this edge's write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      ready    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      rd_valid <= run & rd_en;
      rd_data  <= rd_ok ? mem[rd_idx] : '0;
      err      <= (err_nxt != ERR_NONE);
      err_code <= err_nxt;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_resp.sv
// Scoreboard bench for lsu_dmem_resp: directed loads/stores, error cases, clear and reset timing.
module tb_lsu_dmem_resp;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err;
  logic [1:0]  err_code;

  lsu_dmem_resp #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ready    (ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          v;
    logic [31:0] d;
    bit          e;
    logic [1:0]  c;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented response must match the oldest expectation, in the expected cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_valid || err) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: rd_valid=%0b rd_data=0x%08h err=%0b code=%0d at cycle %0d",
                   rd_valid, rd_data, err, err_code, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.cyc != cyc || e.v != rd_valid || e.d !== rd_data || e.e != err || e.c !== err_code) begin
            fails++;
            $display("FAIL resp: got cyc=%0d v=%0b d=0x%08h err=%0b code=%0d expected cyc=%0d v=%0b d=0x%08h err=%0b code=%0d",
                     cyc, rd_valid, rd_data, err, err_code, e.cyc, e.v, e.d, e.e, e.c);
          end
        end
      end
      if (!rd_valid) chk("rd_data_idle_zero", rd_data, 32'h0);
      if (!err)      chk("err_code_idle_zero", 32'(err_code), 32'h0);
    end
  end

  task automatic expect_resp(input bit v, input logic [31:0] d, input bit e, input logic [1:0] c);
    exp_t x;
    x.cyc = cyc + 1;
    x.v = v; x.d = d; x.e = e; x.c = c;
    q.push_back(x);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [1:0] c);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
    expect_resp(1'b1, d, c != 2'd0, c);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] c);
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (c != 2'd0) expect_resp(1'b0, 32'h0, 1'b1, c);
  endtask

  task automatic both(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] d);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = ra; wr_en = 1'b1; wr_addr = wa; wr_data = d;
    expect_resp(1'b1, 32'h0, 1'b1, 2'd3);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Reset for one cycle, then measure how long ready stays low; optionally hammer requests meanwhile.
  task automatic do_reset(input bit noisy, input bit with_load);
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    if (with_load) begin rd_en = 1'b1; rd_addr = 32'h10; wr_en = 1'b0; end
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = noisy; wr_en = noisy;
    rd_addr = 32'h40; wr_addr = 32'h40; wr_data = 32'hFFFF_0000;
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    n = 1;
    forever begin
      @(negedge clk);
      if (ready || n >= 5000) break;
      n++;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    chk("clear_cycles", 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    do_reset(1'b0, 1'b0);

    load(32'h10, 32'h0, 2'd0);
    store(32'h10, 32'hDEAD_BEEF, 2'd0);
    load(32'h10, 32'hDEAD_BEEF, 2'd0);
    load(32'h6, 32'h0, 2'd1);
    store(32'h1000, 32'hBAD0_0001, 2'd2);
    load(32'h0, 32'h0, 2'd0);
    both(32'h20, 32'h20, 32'h1234_5678);
    load(32'h20, 32'h1234_5678, 2'd0);

    store(32'h0, 32'hA0A0_0001, 2'd0);
    store(32'h4, 32'hB0B0_0002, 2'd0);
    store(32'h8, 32'hC0C0_0003, 2'd0);
    load(32'h0, 32'hA0A0_0001, 2'd0);
    load(32'h4, 32'hB0B0_0002, 2'd0);
    load(32'h8, 32'hC0C0_0003, 2'd0);

    store(32'hFFFF_FFFC, 32'h1111_1111, 2'd2);
    store(32'h1001, 32'h2222_2222, 2'd1);
    store(32'hFFC, 32'h5555_AAAA, 2'd0);
    load(32'hFFC, 32'h5555_AAAA, 2'd0);
    load(32'h1000, 32'h0, 2'd2);
    both(32'h24, 32'h7, 32'h3333_3333);
    load(32'h4, 32'hB0B0_0002, 2'd0);
    idle(3);
    chk("queue_drained_1", 32'(q.size()), 32'h0);

    // Reset mid-clear, then a full clear with requests held active.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (300) @(negedge clk);
    do_reset(1'b1, 1'b0);
    load(32'h40, 32'h0, 2'd0);
    store(32'h10, 32'h7777_8888, 2'd0);
    idle(1);

    // Reset in the same cycle a load is issued: the load must be dropped.
    do_reset(1'b0, 1'b1);
    load(32'h10, 32'h0, 2'd0);
    load(32'hFFC, 32'h0, 2'd0);
    load(32'h4, 32'h0, 2'd0);
    idle(3);
    chk("queue_drained_2", 32'(q.size()), 32'h0);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
